// File: rtl/ecp5_pll_phase_ctl_pkg.sv
// Shared types and constants for the ECP5 PLL dynamic phase sequencer.
package ecp5_pll_phase_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STEP_LO,
      STEP_HI,
      LOAD,
      SETTLE,
      DONE
   } state_e;

   localparam logic [1:0] CH_CLKOP  = 2'd0;
   localparam logic [1:0] CH_CLKOS  = 2'd1;
   localparam logic [1:0] CH_CLKOS2 = 2'd2;
   localparam logic [1:0] CH_CLKOS3 = 2'd3;

endpackage

// File: rtl/ecp5_pll_phase_ctl_if.sv
// Request handshake between a phase-shift requester and the sequencer.
interface ecp5_pll_phase_ctl_if #(
   parameter int COUNT_W = 8
);
   logic               req_valid;
   logic               req_ready;
   logic [1:0]         req_sel;
   logic               req_dir;
   logic [COUNT_W-1:0] req_count;

   modport master (output req_valid, req_sel, req_dir, req_count, input req_ready);
   modport slave  (input req_valid, req_sel, req_dir, req_count, output req_ready);
endinterface

// File: rtl/ecp5_pll_phase_ctl_pll_lock_sync.sv
// Two-flop synchronizer bringing the PLL LOCK pin into the clk domain.
module pll_lock_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic s1;

   // Plain two-stage shift; reads as "not locked" out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         q  <= 1'b0;
      end else begin
         s1 <= d;
         q  <= s1;
      end
   end
endmodule

// File: rtl/ecp5_pll_phase_ctl.sv
// ECP5 EHXPLLL dynamic phase-adjust sequencer: one request at a time, timed
// active-low PHASESTEP/PHASELOADREG strobes, completion after PLL re-lock.
// Optional macro PLL_PHASE_TRACK_EN adds per-channel position counters (pos).
module ecp5_pll_phase_ctl #(
   parameter int SETUP      = 2,
   parameter int STEP_LOW   = 4,
   parameter int STEP_HIGH  = 4,
   parameter int LOAD_WIDTH = 4,
   parameter int COUNT_W    = 8,
   parameter int POS_W      = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   ecp5_pll_phase_ctl_if.slave req,
   input  logic                pll_locked,
   output logic [1:0]          phasesel,
   output logic                phasedir,
   output logic                phasestep,
   output logic                phaseloadreg,
   output logic                busy,
   output logic                done
`ifdef PLL_PHASE_TRACK_EN
   ,
   output logic [4*POS_W-1:0]  pos
`endif
);
   import ecp5_pll_phase_pkg::*;

   // One down-counter serves every timed state, so size it for the longest.
   localparam int M1   = (SETUP > STEP_LOW) ? SETUP : STEP_LOW;
   localparam int M2   = (STEP_HIGH > LOAD_WIDTH) ? STEP_HIGH : LOAD_WIDTH;
   localparam int MAXD = (M1 > M2) ? M1 : M2;
   localparam int CW   = $clog2(MAXD + 1);

   localparam logic [CW-1:0] SETUP_LD = CW'(SETUP - 1);
   localparam logic [CW-1:0] LO_LD    = CW'(STEP_LOW - 1);
   localparam logic [CW-1:0] HI_LD    = CW'(STEP_HIGH - 1);
   localparam logic [CW-1:0] LOAD_LD  = CW'(LOAD_WIDTH - 1);

   state_e             state, state_nxt;
   logic [CW-1:0]      cnt, cnt_nxt;
   logic [COUNT_W-1:0] steps, steps_nxt;
   logic               locked_s;
   logic               accept;

   pll_lock_sync u_lock_sync (.clk(clk), .rst_n(rst_n), .d(pll_locked), .q(locked_s));

   // req_ready is only ever high while IDLE, so this implies IDLE.
   assign accept = req.req_valid & req.req_ready;

   // Next state, cycle counter and remaining-step bookkeeping.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt - 1'b1;
      steps_nxt = steps;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (accept) begin
               steps_nxt = req.req_count;
               if (req.req_count == '0) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = ecp5_pll_phase_pkg::SETUP;
                  cnt_nxt   = SETUP_LD;
               end
            end
         end
         ecp5_pll_phase_pkg::SETUP: begin
            if (cnt == '0) begin
               state_nxt = STEP_LO;
               cnt_nxt   = LO_LD;
            end
         end
         STEP_LO: begin
            if (cnt == '0) begin
               state_nxt = STEP_HI;
               cnt_nxt   = HI_LD;
            end
         end
         STEP_HI: begin
            if (cnt == '0) begin
               steps_nxt = steps - 1'b1;
               if (steps != COUNT_W'(1)) begin
                  state_nxt = STEP_LO;
                  cnt_nxt   = LO_LD;
               end else begin
                  state_nxt = LOAD;
                  cnt_nxt   = LOAD_LD;
               end
            end
         end
         LOAD: begin
            if (cnt == '0) begin
               state_nxt = SETTLE;
               cnt_nxt   = '0;
            end
         end
         SETTLE: begin
            cnt_nxt = '0;
            if (locked_s) state_nxt = DONE;
         end
         DONE: begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
         end
         default: begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         steps <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         steps <= steps_nxt;
      end
   end

   // Outputs registered from next state so the PLL pins never see decode glitches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req.req_ready <= 1'b0;
         phasesel      <= '0;
         phasedir      <= 1'b0;
         phasestep     <= 1'b1;
         phaseloadreg  <= 1'b1;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         req.req_ready <= (state_nxt == IDLE) & locked_s;
         if (accept) begin
            phasesel <= req.req_sel;
            phasedir <= req.req_dir;
         end
         phasestep    <= (state_nxt != STEP_LO);
         phaseloadreg <= (state_nxt != LOAD);
         busy         <= !(state_nxt inside {IDLE, DONE});
         done         <= (state_nxt == DONE);
      end
   end

`ifdef PLL_PHASE_TRACK_EN
   logic [3:0][POS_W-1:0] pos_q;

   assign pos = pos_q;

   // Track each channel's net step count at the end of every low strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos_q <= '0;
      end else if (state == STEP_LO && cnt == '0) begin
         pos_q[phasesel] <= phasedir ? pos_q[phasesel] + 1'b1 : pos_q[phasesel] - 1'b1;
      end
   end
`endif

endmodule
